mmio_uart_tx: RTL and testbench
===============================

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning serial bit rate.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_1000, meaning byte address of the TXDATA register; STATUS is at BASE_ADDR+4.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, meaning TX FIFO entries; must be a power of two, at least 2.
REQ-005 SHALL have port CLOCK_50  input  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port resetn  input  1  synchronous active-low reset.
REQ-007 SHALL have port addr  input  32  CPU data-bus byte address.
REQ-008 SHALL have port write_data  input  32  CPU store data.
REQ-009 SHALL have port mem_write  input  1  CPU store strobe, one cycle per store.
REQ-010 SHALL have port byte_enable  input  4  CPU store byte lanes.
REQ-011 SHALL have port read_data  output  32  register read value, combinational from addr.
REQ-012 SHALL have port sel  output  1  high when addr equals BASE_ADDR or BASE_ADDR+4; top uses it to mux read data.
REQ-013 SHALL have port uart_txd  output  1  serial line, idle high.

Function
REQ-014 Bit period SHALL be DIV = CLK_HZ/BAUD clock cycles, using integer truncation (default 434).
REQ-015 Push SHALL occur at a rising edge with:
- mem_write=1
- addr=BASE_ADDR
- byte_enable[0]=1
- FIFO not full
The pushed byte is write_data[7:0].
REQ-016 A qualifying store SHALL be dropped when the FIFO is full. The fullness check uses the pre-edge count, so a same-edge pop does not make room. A dropped store SHALL set sticky OVF.
REQ-017 A store to BASE_ADDR+4 with byte_enable[0]=1 and write_data[3]=1 SHALL clear OVF. If a drop and a clear occur on the same edge, the drop SHALL win and OVF ends set.
REQ-018 Stores outside the two addresses, or with byte_enable[0]=0, SHALL have no effect.
REQ-019 read_data at BASE_ADDR+4 SHALL be:
- bit0 FULL
- bit1 EMPTY
- bit2 BUSY (FSM not IDLE)
- bit3 OVF
- bits[7:4] COUNT (0..FIFO_DEPTH)
- all other bits 0
read_data at BASE_ADDR SHALL read 0. read_data SHALL be 0 when sel=0.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH. COUNT SHALL be unchanged on a simultaneous push and pop.
REQ-021 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-022 IDLE SHALL drive uart_txd=1. When the FIFO is non-empty at an edge, the FSM SHALL pop the head byte into the shift register and enter START.
REQ-023 START SHALL drive uart_txd=0 for DIV cycles, then enter DATA.
REQ-024 DATA SHALL drive the 8 bits LSB first, DIV cycles each; a 3-bit index selects the bit. After bit 7 the FSM SHALL enter STOP.
REQ-025 STOP SHALL drive uart_txd=1 for DIV cycles. On the final STOP cycle:
- if the FIFO is non-empty, pop and enter START directly (no idle gap);
- otherwise enter IDLE.
REQ-026 A frame SHALL be exactly 10*DIV cycles.
REQ-027 Latency SHALL be as follows for a push at edge k with the FSM in IDLE and the FIFO empty: pop at edge k+1, uart_txd low from edge k+1.
REQ-028 uart_txd SHALL be registered and glitch-free.

Reset
REQ-029 With resetn=0 at an edge, the block SHALL set:
- FIFO pointers and COUNT to 0 (contents discarded)
- OVF to 0
- FSM to IDLE
- baud counter and bit index to 0
- uart_txd to 1
REQ-030 Reset asserted mid-frame SHALL abort the frame; uart_txd SHALL be 1 after that edge. A store on the reset edge SHALL be ignored.
REQ-031 After reset, read_data at STATUS SHALL be 32'h0000_0002.

Verification
REQ-032 Setup: CLK_HZ=1000, BAUD=100 (DIV=10). Store 8'hA5 to BASE_ADDR -> txd low from next edge for 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, stop high 10 cycles, then IDLE.
REQ-033 Store 9 bytes back-to-back while the FSM is busy with an earlier frame -> STATUS shows FULL=1, COUNT=8, OVF=1; the 9th byte is never transmitted.
REQ-034 Store 2 bytes -> two 100-cycle frames with no idle cycle between STOP and the second START.
REQ-035 Write 32'h8 to BASE_ADDR+4 with OVF=1 -> OVF=0; a store with byte_enable=4'b0010 to BASE_ADDR -> no push, COUNT unchanged.
REQ-036 Assert resetn=0 during DATA bit 3 -> txd=1 and STATUS=32'h2 after that edge; no residual frame output after release.
REQ-037 Read addr=BASE_ADDR+8 -> sel=0, read_data=0; read BASE_ADDR+4 -> sel=1.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: CPU stores bytes into a small TX FIFO,
// a 4-state serializer sends 8N1 frames on uart_txd.
module mmio_uart_tx #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        mem_write,
  input  logic [3:0]  byte_enable,
  output logic [31:0] read_data,
  output logic        sel,
  output logic        uart_txd
);

  localparam int unsigned DIV    = CLK_HZ / BAUD;
  localparam int unsigned BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              ovf;

  logic [1:0]        state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              txd_q;

  logic [1:0]        next_state;
  logic [BAUD_W-1:0] next_baud_cnt;
  logic [2:0]        next_bit_idx;
  logic [7:0]        next_shreg;
  logic              next_txd;

  logic full_c;
  logic empty_c;
  logic data_store_c;
  logic push_c;
  logic drop_c;
  logic clr_c;
  logic pop_c;
  logic last_c;
  logic unused_c;

  assign full_c       = (count == CNT_W'(FIFO_DEPTH));
  assign empty_c      = (count == '0);
  assign data_store_c = mem_write && (addr == BASE_ADDR) && byte_enable[0];
  assign push_c       = data_store_c && !full_c;
  assign drop_c       = data_store_c && full_c;
  assign clr_c        = mem_write && (addr == STATUS_ADDR) && byte_enable[0] && write_data[3];
  assign last_c       = (baud_cnt == BAUD_W'(DIV - 1));
  assign unused_c     = ^{write_data[31:8], byte_enable[3:1]};

  // FIFO bookkeeping and sticky overflow; a drop beats a same-edge clear
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop_c)     ovf <= 1'b1;
      else if (clr_c) ovf <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (resetn && push_c) fifo_mem[wr_ptr] <= write_data[7:0];
  end

  // FSM state register; the line level is registered alongside the state
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      txd_q    <= 1'b1;
    end else begin
      state    <= next_state;
      baud_cnt <= next_baud_cnt;
      bit_idx  <= next_bit_idx;
      shreg    <= next_shreg;
      txd_q    <= next_txd;
    end
  end

  // Next-state logic; next_txd is the level for the cycle being entered
  always_comb begin
    next_state    = state;
    next_baud_cnt = baud_cnt;
    next_bit_idx  = bit_idx;
    next_shreg    = shreg;
    next_txd      = txd_q;
    pop_c         = 1'b0;
    case (state)
      S_IDLE: begin
        next_txd = 1'b1;
        if (!empty_c) begin
          pop_c         = 1'b1;
          next_shreg    = fifo_mem[rd_ptr];
          next_state    = S_START;
          next_baud_cnt = '0;
          next_txd      = 1'b0;
        end
      end
      S_START: begin
        if (last_c) begin
          next_baud_cnt = '0;
          next_bit_idx  = '0;
          next_state    = S_DATA;
          next_txd      = shreg[0];
        end else begin
          next_baud_cnt = baud_cnt + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (last_c) begin
          next_baud_cnt = '0;
          if (bit_idx == 3'd7) begin
            next_state = S_STOP;
            next_txd   = 1'b1;
          end else begin
            next_bit_idx = bit_idx + 3'd1;
            next_txd     = shreg[bit_idx + 3'd1];
          end
        end else begin
          next_baud_cnt = baud_cnt + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (last_c) begin
          next_baud_cnt = '0;
          if (!empty_c) begin
            pop_c      = 1'b1;
            next_shreg = fifo_mem[rd_ptr];
            next_state = S_START;
            next_txd   = 1'b0;
          end else begin
            next_state = S_IDLE;
            next_txd   = 1'b1;
          end
        end else begin
          next_baud_cnt = baud_cnt + BAUD_W'(1);
        end
      end
      default: begin
        next_state = S_IDLE;
        next_txd   = 1'b1;
      end
    endcase
  end

  // Register read mux
  always_comb begin
    read_data = '0;
    if (addr == STATUS_ADDR) begin
      read_data = {24'd0, 4'(count), ovf, (state != S_IDLE), empty_c, full_c};
    end
  end

  assign sel      = (addr == BASE_ADDR) || (addr == STATUS_ADDR);
  assign uart_txd = txd_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx at DIV=10: a serial monitor decodes frames and checks
// them against a queue of expected bytes filled by the stimulus.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] STAT = 32'h0000_1004;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        mem_write;
  logic [3:0]  byte_enable;
  logic [31:0] read_data;
  logic        sel;
  logic        uart_txd;

  mmio_uart_tx #(
    .CLK_HZ(1000), .BAUD(100), .BASE_ADDR(BASE), .FIFO_DEPTH(8)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn), .addr(addr), .write_data(write_data),
    .mem_write(mem_write), .byte_enable(byte_enable), .read_data(read_data),
    .sel(sel), .uart_txd(uart_txd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit         b2b;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Serial monitor: start at first low cycle, sample each bit at its centre
  int         cyc = 0;
  int         mon_pos = 0;
  int         start_cyc = 0;
  int         prev_start = 0;
  bit         mon_active = 0;
  logic [9:0] bits;
  exp_t       e;

  always @(negedge clk) begin
    cyc++;
    if (resetn !== 1'b1) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (uart_txd === 1'b0) begin
        mon_active = 1;
        mon_pos    = 0;
        start_cyc  = cyc;
      end
    end else begin
      mon_pos++;
      if (mon_pos % 10 == 5) bits[4'(mon_pos / 10)] = uart_txd;
      if (mon_pos == 95) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got byte %h required no frame", bits[8:1]);
        end else begin
          e = q.pop_front();
          check("frame_data", 32'(bits[8:1]), 32'(e.d));
          check("start_bit", 32'(bits[0]), 32'd0);
          check("stop_bit", 32'(bits[9]), 32'd1);
          if (e.b2b) check("b2b_gap", 32'(start_cyc - prev_start), 32'd100);
        end
        prev_start = start_cyc;
        mon_active = 0;
      end
    end
  end

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr        = a;
    write_data  = d;
    byte_enable = be;
    mem_write   = 1'b1;
    @(negedge clk);
    mem_write   = 1'b0;
    byte_enable = 4'd0;
  endtask

  task automatic read_chk(input string name, input logic [31:0] a,
                          input logic [31:0] exp_rd, input logic exp_sel);
    addr = a;
    #1;
    check({name, "_rd"}, read_data, exp_rd);
    check({name, "_sel"}, 32'(sel), 32'(exp_sel));
  endtask

  task automatic wait_idle(input int budget);
    bit done = 0;
    addr = STAT;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0 && !mon_active && read_data == 32'h2) done = 1;
    end
    check("idle_reached", 32'(done), 32'd1);
  endtask

  initial begin
    int lows;
    resetn      = 1'b0;
    addr        = STAT;
    write_data  = '0;
    mem_write   = 1'b0;
    byte_enable = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_txd", 32'(uart_txd), 32'd1);
    read_chk("reset_status", STAT, 32'h2, 1'b1);
    resetn = 1'b1;
    @(negedge clk);

    // Single frame with push-to-start latency
    q.push_back('{d: 8'hA5, b2b: 0});
    store(BASE, 32'hFFFF_FFA5, 4'h1);
    check("lat_txd_k", 32'(uart_txd), 32'd1);
    read_chk("lat_status_k", STAT, 32'h10, 1'b1);
    @(negedge clk);
    check("lat_txd_k1", 32'(uart_txd), 32'd0);
    read_chk("lat_status_k1", STAT, 32'h06, 1'b1);
    wait_idle(300);

    // Two stores, second frame follows STOP with no idle gap
    q.push_back('{d: 8'h3C, b2b: 0});
    q.push_back('{d: 8'hC3, b2b: 1});
    store(BASE, 32'h3C, 4'h1);
    store(BASE, 32'hC3, 4'h1);
    wait_idle(400);

    // Stores that must not push
    store(BASE, 32'h55, 4'b0010);
    read_chk("be_lane1", STAT, 32'h2, 1'b1);
    store(BASE + 32'd8, 32'h66, 4'hF);
    read_chk("other_addr", STAT, 32'h2, 1'b1);
    repeat (20) @(negedge clk);
    check("no_frame_txd", 32'(uart_txd), 32'd1);

    // Fill the FIFO while a frame is in flight, then overflow
    q.push_back('{d: 8'h11, b2b: 0});
    store(BASE, 32'h11, 4'h1);
    repeat (2) @(negedge clk);
    read_chk("busy_empty", STAT, 32'h06, 1'b1);
    for (int i = 0; i < 8; i++) begin
      q.push_back('{d: 8'(8'h21 + i), b2b: 1});
      store(BASE, 32'(8'h21 + i), 4'h1);
    end
    read_chk("full8", STAT, 32'h85, 1'b1);
    store(BASE, 32'h29, 4'h1);
    read_chk("ovf_set", STAT, 32'h8D, 1'b1);
    store(STAT, 32'h8, 4'b0010);
    read_chk("clr_no_lane0", STAT, 32'h8D, 1'b1);
    store(STAT, 32'h8, 4'h1);
    read_chk("ovf_clr", STAT, 32'h85, 1'b1);
    store(BASE, 32'h2A, 4'h1);
    read_chk("ovf_again", STAT, 32'h8D, 1'b1);
    store(STAT, 32'h8, 4'h1);
    read_chk("ovf_clr2", STAT, 32'h85, 1'b1);
    wait_idle(3000);

    // Reset during DATA bit 3 aborts the frame; store on the reset edge ignored
    store(BASE, 32'h5A, 4'h1);
    repeat (45) @(negedge clk);
    check("mid_bit3_txd", 32'(uart_txd), 32'd1);
    resetn      = 1'b0;
    addr        = BASE;
    write_data  = 32'h77;
    byte_enable = 4'h1;
    mem_write   = 1'b1;
    @(negedge clk);
    mem_write   = 1'b0;
    byte_enable = 4'd0;
    check("abort_txd", 32'(uart_txd), 32'd1);
    read_chk("abort_status", STAT, 32'h2, 1'b1);
    resetn = 1'b1;
    lows   = 0;
    repeat (150) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) lows++;
    end
    check("no_residual_frame", 32'(lows), 32'd0);
    read_chk("post_reset_status", STAT, 32'h2, 1'b1);

    // Address decode
    read_chk("addr_plus8", BASE + 32'd8, 32'h0, 1'b0);
    read_chk("addr_txdata", BASE, 32'h0, 1'b1);
    read_chk("addr_status", STAT, 32'h2, 1'b1);

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
